// File: rtl/vector_pkg.sv
// Shared definitions for the memory burst scheduler and its helpers.
//   sched_state_e   : scheduler FSM states (IDLE, BURST)
//   NUM_OF_CORES    : number of requesting cores (sets NUM_REQ)
//   ACCESS_LEN_W    : width of a core's access_length field
//   MAX_OUTSTANDING : bursts a core may have granted but not yet responded
//   OUT_CNT_W       : width of a per-core outstanding counter (holds MAX_OUTSTANDING)
package vector_pkg;

  localparam int NUM_OF_CORES    = 4;
  localparam int ACCESS_LEN_W    = 8;
  localparam int MAX_OUTSTANDING = 4;
  localparam int OUT_CNT_W       = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Starting just above the pointer and
// wrapping around, returns the first requester that is set.
//   req_i      : request vector
//   ptr_i      : index of the most recently served requester
//   pick_o     : one-hot pick, all zero when nothing requests
//   pick_idx_o : binary index of the pick, 0 when nothing requests
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         pick_o,
  output logic [$clog2(N)-1:0] pick_idx_o
);

  localparam int IDX_W = $clog2(N);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable written here gets a default before any branch, so no
  // path can leave a value held over from a previous evaluation (no latches).
  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    idx        = '0;
    // Offsets 1..N visit every requester once, the pointer's own slot last.
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        pick_idx_o  = idx;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Memory burst scheduler. Grants the shared memory request port to one core at
// a time in round-robin order and holds the grant for the whole burst. Tracks
// per-core outstanding bursts against memory responses; a core whose credits
// are exhausted is skipped.
//   clk, reset    : clock, asynchronous active-low reset
//   req_vld       : per-core request valid
//   req_len       : per-core access_length, core i at [i*LEN_W +: LEN_W]
//   mem_rdy       : memory accepts a beat this cycle
//   rsp_vld       : memory response valid (completes one burst)
//   rsp_core_id   : core that the response belongs to
//   grant         : one-hot registered grant (mux select), 0 when idle
//   grant_idx     : index of the granted core, 0 when idle
//   beat_last     : the beat accepted this cycle ends the burst
//   busy          : a burst is in progress
//   abort         : one-cycle pulse, the grantee dropped its request mid-burst
//   err_underflow : sticky, a response arrived for a core with nothing outstanding
//   outstanding   : per-core outstanding counts, core i at [i*CNT_W +: CNT_W]
module mem_burst_scheduler
  import vector_pkg::*;
#(
  parameter int NUM_REQ = NUM_OF_CORES,
  parameter int LEN_W   = ACCESS_LEN_W,
  parameter int MAX_OUT = MAX_OUTSTANDING,
  parameter int CNT_W   = OUT_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic                       mem_rdy,
  input  logic                       rsp_vld,
  input  logic [3:0]                 rsp_core_id,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       beat_last,
  output logic                       busy,
  output logic                       abort,
  output logic                       err_underflow,
  output logic [NUM_REQ*CNT_W-1:0]   outstanding
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e     state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             abort_q, abort_d;
  logic             err_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] uf_evt;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic [LEN_W-1:0]   len_a [NUM_REQ];
  logic               grantee_vld;
  logic               beat_acc;

  // Per-core credit counters. A burst is charged on its last beat and
  // refunded by the matching response; both together cancel out.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_core
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt_q;

    assign inc = beat_last && (grant_idx_q == IDX_W'(i));
    // Ids at or above NUM_REQ never match any core and are dropped here.
    assign dec = rsp_vld && (rsp_core_id == 4'(i));
    assign uf_evt[i] = dec && !inc && (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (inc && !dec) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    assign eligible[i] = req_vld[i] && (cnt_q < CNT_W'(MAX_OUT));
    assign outstanding[i*CNT_W +: CNT_W] = cnt_q;
    assign len_a[i] = req_len[i*LEN_W +: LEN_W];
  end

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req_i      (eligible),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx)
  );

  assign grantee_vld = req_vld[grant_idx_q];
  assign beat_acc    = (state_q == BURST) && mem_rdy && grantee_vld;
  assign beat_last   = beat_acc && (beat_cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    abort_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d     = pick;
          grant_idx_d = pick_idx;
          // A zero length still moves one beat.
          len_d       = (len_a[pick_idx] == '0) ? LEN_W'(1) : len_a[pick_idx];
          beat_cnt_d  = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!grantee_vld) begin
          abort_d     = 1'b1;
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          beat_cnt_d  = '0;
          ptr_d       = grant_idx_q;
        end else if (mem_rdy) begin
          if (beat_last) begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
            beat_cnt_d  = '0;
            ptr_d       = grant_idx_q;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      len_q       <= '0;
      beat_cnt_q  <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      abort_q     <= abort_d;
      err_q       <= err_q | (|uf_evt);
    end
  end

  assign grant         = grant_q;
  assign grant_idx     = grant_idx_q;
  assign busy          = (state_q == BURST);
  assign abort         = abort_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Self-checking bench for mem_burst_scheduler: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_mem_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_vld;
  logic [31:0] req_len;
  logic        mem_rdy;
  logic        rsp_vld;
  logic [3:0]  rsp_core_id;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        beat_last;
  logic        busy;
  logic        abort;
  logic        err_underflow;
  logic [11:0] outstanding;

  mem_burst_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req_vld       (req_vld),
    .req_len       (req_len),
    .mem_rdy       (mem_rdy),
    .rsp_vld       (rsp_vld),
    .rsp_core_id   (rsp_core_id),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .beat_last     (beat_last),
    .busy          (busy),
    .abort         (abort),
    .err_underflow (err_underflow),
    .outstanding   (outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which core owns the port (-1 = nobody), how many beats of
  // its burst are done, where the rotation last stopped, and per-core credits.
  int m_owner, m_len, m_done, m_ptr;
  int m_out [4];
  bit m_err, m_abort;

  task automatic model_rst();
    m_owner = -1; m_len = 0; m_done = 0; m_ptr = 3;
    m_err = 0; m_abort = 0;
    for (int c = 0; c < 4; c++) m_out[c] = 0;
  endtask

  function automatic int len_of(input int c);
    int v;
    v = int'(8'(req_len >> (c * 8)));
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit vld_of(input int c);
    return req_vld[2'(c)];
  endfunction

  // One clock edge of the protocol, using the inputs held across that edge.
  task automatic model_adv();
    int inc, rid, c;
    bit ab;
    inc = -1; ab = 0;
    rid = int'(rsp_core_id);
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && vld_of(c) && m_out[c] < 4) begin
          m_owner = c; m_len = len_of(c); m_done = 0;
        end
      end
    end else if (!vld_of(m_owner)) begin
      ab = 1; m_ptr = m_owner; m_owner = -1; m_done = 0;
    end else if (mem_rdy) begin
      m_done++;
      if (m_done == m_len) begin
        inc = m_owner; m_ptr = m_owner; m_owner = -1; m_done = 0;
      end
    end
    if (rsp_vld && rid < 4) begin
      if (rid == inc) inc = -1;
      else if (m_out[rid] == 0) m_err = 1;
      else m_out[rid]--;
    end
    if (inc >= 0) m_out[inc]++;
    m_abort = ab;
  endtask

  task automatic compare();
    logic [3:0]  eg;
    logic [1:0]  ei;
    logic [11:0] eo;
    bit          bl;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    ei = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
    bl = (m_owner >= 0) && mem_rdy && vld_of(m_owner) && (m_done == m_len - 1);
    eo = '0;
    for (int c = 0; c < 4; c++) eo = eo | (12'(m_out[c]) << (c * 3));
    check("grant",         32'(grant),         32'(eg));
    check("grant_idx",     32'(grant_idx),     32'(ei));
    check("beat_last",     32'(beat_last),     32'(bl));
    check("busy",          32'(busy),          32'(m_owner >= 0));
    check("abort",         32'(abort),         32'(m_abort));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
    check("outstanding",   32'(outstanding),   32'(eo));
  endtask

  // Inputs are set before calling; compared mid-cycle, then one edge taken.
  task automatic step();
    @(negedge clk);
    #1 compare();
    @(posedge clk);
    if (reset) model_adv(); else model_rst();
    #1;
  endtask

  task automatic clear_inputs();
    req_vld = '0; req_len = '0; mem_rdy = 1'b0; rsp_vld = 1'b0; rsp_core_id = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    clear_inputs();
    #1 model_rst();
    step();
    reset = 1'b1;
  endtask

  int q_order [$];
  int rid;
  logic [3:0] flips;

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_rst();
    step();
    step();
    check("reset_outputs", 32'({grant, grant_idx, beat_last, busy, abort, err_underflow, outstanding}), 32'd0);
    reset = 1'b1;

    // Single core: core1, len 3.
    req_vld = 4'b0010; req_len = 32'h0000_0300; mem_rdy = 1'b1;
    step();
    check("single_grant", 32'(grant), 32'h2);
    step(); step();
    check("single_held", 32'(grant), 32'h2);
    step();
    check("single_done", 32'(grant), 32'h0);
    check("single_out1", 32'(outstanding[5:3]), 32'd1);
    req_vld = '0;
    step();

    // Round robin with a response on every last beat.
    reset_dut();
    req_vld = 4'b1111; req_len = 32'h0101_0101; mem_rdy = 1'b1;
    for (int n = 0; n < 9; n++) begin
      rsp_vld = (m_owner >= 0);
      rsp_core_id = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
      step();
      if (busy) q_order.push_back(int'(grant_idx));
    end
    rsp_vld = 1'b0;
    check("rr_count", 32'(q_order.size()), 32'd5);
    for (int k = 0; k < 5 && k < q_order.size(); k++)
      check("rr_order", 32'(q_order[k]), 32'(k % 4));
    check("rr_out_zero", 32'(outstanding), 32'd0);

    // Stall then abort on core2, len 4.
    reset_dut();
    req_vld = 4'b0100; req_len = 32'h0004_0000; mem_rdy = 1'b1;
    step(); step();
    mem_rdy = 1'b0;
    step(); step();
    check("stall_grant", 32'(grant), 32'h4);
    mem_rdy = 1'b1; req_len = 32'h0001_0000;
    step();
    req_vld = 4'b0000;
    step();
    check("abort_pulse", 32'(abort), 32'd1);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_out2", 32'(outstanding[8:6]), 32'd0);
    step();
    check("abort_clear", 32'(abort), 32'd0);

    // Credit limit on core0.
    reset_dut();
    req_vld = 4'b0001; req_len = 32'h0200_0001; mem_rdy = 1'b1;
    for (int n = 0; n < 8; n++) step();
    check("credit_full", 32'(outstanding[2:0]), 32'd4);
    req_vld = 4'b1001;
    step();
    check("credit_core3", 32'(grant), 32'h8);
    step(); step();
    req_vld = 4'b0001; rsp_vld = 1'b1; rsp_core_id = 4'd0;
    step();
    check("credit_blocked", 32'(grant), 32'd0);
    rsp_vld = 1'b0;
    step();
    check("credit_regrant", 32'(grant), 32'h1);
    step();

    // len 0 on core3, underflow, ignored id.
    reset_dut();
    req_vld = 4'b1000; req_len = 32'h0; mem_rdy = 1'b1;
    step();
    check("len0_grant", 32'(grant), 32'h8);
    step();
    check("len0_done", 32'(grant), 32'd0);
    check("len0_out3", 32'(outstanding[11:9]), 32'd1);
    req_vld = '0; rsp_vld = 1'b1; rsp_core_id = 4'd0;
    step();
    check("underflow_set", 32'(err_underflow), 32'd1);
    rsp_core_id = 4'd9;
    step();
    rsp_vld = 1'b0;
    step();
    check("underflow_sticky", 32'(err_underflow), 32'd1);
    check("bad_id_ignored", 32'(outstanding), 32'h200);

    // Reset during beat 2 of a 5-beat burst.
    reset_dut();
    req_vld = 4'b0001; req_len = 32'h5; mem_rdy = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check("midrst_zero", 32'({grant, grant_idx, beat_last, busy, abort, err_underflow, outstanding}), 32'd0);
    model_rst();
    step();
    reset = 1'b1; req_vld = 4'b1111;
    step();
    check("midrst_core0", 32'(grant), 32'h1);

    // Randomized traffic.
    reset_dut();
    req_vld = 4'($urandom_range(0, 15));
    for (int n = 0; n < 3000; n++) begin
      flips = '0;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 99) < 6) flips = flips | 4'(1 << c);
      req_vld = req_vld ^ flips;
      req_len = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
      mem_rdy = ($urandom_range(0, 3) != 0);
      rid = $urandom_range(0, 5);
      rsp_vld = ($urandom_range(0, 2) == 0) &&
                (rid >= 4 || m_out[rid % 4] > 0 || $urandom_range(0, 15) == 0);
      rsp_core_id = 4'(rid);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        #1 model_rst();
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
